// File: rtl/operand_fetch.sv
// Operand fetch stage: decodes register fields, reads the register file with
// writeback bypass, and registers an operand bundle behind a valid/ready handshake.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] in_pc,
    output logic [REG_AW-1:0] Aa,
    output logic [REG_AW-1:0] Ab,
    input  logic [DATA_W-1:0] Da,
    input  logic [DATA_W-1:0] Db,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_opA,
    output logic [DATA_W-1:0] out_opB,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc,
    output logic [5:0]        out_opcode
);

    localparam logic [5:0] OP_LW = 6'b100011;

    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [5:0]        opcode;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              advance;
    logic              hazard;
    logic              accept;

    assign rs      = instr[21 +: REG_AW];
    assign rt      = instr[16 +: REG_AW];
    assign rd      = instr[11 +: REG_AW];
    assign opcode  = instr[31:26];
    assign imm_ext = {{(DATA_W-16){instr[15]}}, instr[15:0]};

    assign Aa = rs;
    assign Ab = rt;

    // Register 0 is hardwired to zero, so it wins over any bypassed write.
    always_comb begin
        op_a = Da;
        if (rs == '0)
            op_a = '0;
        else if (wb_en && (wb_addr == rs))
            op_a = wb_data;
    end

    always_comb begin
        op_b = Db;
        if (rt == '0)
            op_b = '0;
        else if (wb_en && (wb_addr == rt))
            op_b = wb_data;
    end

    // Load-use: the held load's result is not available until after this stage.
    assign advance = !out_valid || out_ready;
    assign hazard  = in_valid && out_valid && (out_opcode == OP_LW) && (out_rt != '0)
                     && ((out_rt == rs) || (out_rt == rt));
    assign in_ready = !reset && advance && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_opA    <= '0;
            out_opB    <= '0;
            out_rs     <= '0;
            out_rt     <= '0;
            out_rd     <= '0;
            out_imm    <= '0;
            out_pc     <= '0;
            out_opcode <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            if (accept) begin
                out_valid  <= 1'b1;
                out_opA    <= op_a;
                out_opB    <= op_b;
                out_rs     <= rs;
                out_rt     <= rt;
                out_rd     <= rd;
                out_imm    <= imm_ext;
                out_pc     <= in_pc;
                out_opcode <= opcode;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: register-file model on the read ports,
// scenario tasks with hand-computed expectations.
module tb_operand_fetch;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] in_pc;
    logic [REG_AW-1:0] Aa;
    logic [REG_AW-1:0] Ab;
    logic [DATA_W-1:0] Da;
    logic [DATA_W-1:0] Db;
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_opA;
    logic [DATA_W-1:0] out_opB;
    logic [REG_AW-1:0] out_rs;
    logic [REG_AW-1:0] out_rt;
    logic [REG_AW-1:0] out_rd;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_pc;
    logic [5:0]        out_opcode;

    logic [DATA_W-1:0] regs [32];
    int n_checks;
    int n_fail;

    assign Da = regs[Aa];
    assign Db = regs[Ab];

    operand_fetch #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .in_pc(in_pc), .Aa(Aa), .Ab(Ab), .Da(Da), .Db(Db),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_opA(out_opA),
        .out_opB(out_opB), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_imm(out_imm), .out_pc(out_pc), .out_opcode(out_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s,
                                       input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; instr = mk(6'h08, 5'd3, 5'd4, 16'h7777); in_pc = 32'h40;
        tick(); tick();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_checks++; if (out_imm !== 32'h0) begin n_fail++; $display("FAIL reset_imm got %h want 0", out_imm); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", out_pc); end
        n_checks++; if (out_opA !== 32'h0) begin n_fail++; $display("FAIL reset_opA got %h want 0", out_opA); end
    endtask

    task automatic test_basic();
        tick();
        reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        instr = mk(6'h00, 5'd4, 5'd4, 16'h2834); in_pc = 32'h100;
        @(negedge clk);
        n_checks++; if (Aa !== 5'd4 || Ab !== 5'd4) begin n_fail++; $display("FAIL addr_decode got %0d/%0d want 4/4", Aa, Ab); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL first_accept_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", out_valid); end
        n_checks++; if (out_opA !== 32'd69 || out_opB !== 32'd69) begin n_fail++; $display("FAIL basic_ops got %0d/%0d want 69/69", out_opA, out_opB); end
        n_checks++; if (out_pc !== 32'h100 || out_imm !== 32'h2834) begin n_fail++; $display("FAIL basic_pc_imm got %h/%h want 100/2834", out_pc, out_imm); end
        n_checks++; if (out_rs !== 5'd4 || out_rt !== 5'd4 || out_rd !== 5'd5) begin n_fail++; $display("FAIL basic_regs got %0d/%0d/%0d want 4/4/5", out_rs, out_rt, out_rd); end
        tick();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_drains got %b want 0", out_valid); end
    endtask

    task automatic test_bypass();
        tick();
        in_valid = 1'b1; wb_en = 1'b1; wb_addr = 5'd25; wb_data = 32'd420;
        instr = mk(6'h00, 5'd25, 5'd0, 16'h0); in_pc = 32'h200;
        tick();
        @(negedge clk);
        n_checks++; if (out_opA !== 32'd420) begin n_fail++; $display("FAIL bypass_opA got %0d want 420", out_opA); end
        n_checks++; if (out_opB !== 32'd0) begin n_fail++; $display("FAIL r0_opB got %0d want 0", out_opB); end
        wb_addr = 5'd24;
        tick();
        @(negedge clk);
        n_checks++; if (out_opA !== 32'd7) begin n_fail++; $display("FAIL no_bypass_opA got %0d want 7", out_opA); end
        wb_addr = 5'd0; instr = mk(6'h00, 5'd0, 5'd25, 16'h0);
        tick();
        @(negedge clk);
        n_checks++; if (out_opA !== 32'd0) begin n_fail++; $display("FAIL bypass_r0_opA got %0d want 0", out_opA); end
        n_checks++; if (out_opB !== 32'd7) begin n_fail++; $display("FAIL rt_regfile_opB got %0d want 7", out_opB); end
        wb_en = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        in_valid = 1'b1; out_ready = 1'b1;
        instr = mk(6'b100011, 5'd1, 5'd8, 16'h0004); in_pc = 32'h300;
        tick();
        instr = mk(6'h00, 5'd8, 5'd2, 16'h0); in_pc = 32'h304;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_opcode !== 6'b100011) begin n_fail++; $display("FAIL lw_held got %b/%h want 1/23", out_valid, out_opcode); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hazard_stall got %b want 0", in_ready); end
        tick();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_bubble_ready got %b want 1", in_ready); end
        tick();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h304 || out_rs !== 5'd8) begin n_fail++; $display("FAIL after_bubble got %b/%h/%0d want 1/304/8", out_valid, out_pc, out_rs); end
        instr = mk(6'b100011, 5'd1, 5'd0, 16'h0); in_pc = 32'h308;
        tick();
        instr = mk(6'h00, 5'd0, 5'd0, 16'h0); in_pc = 32'h30C;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lw_r0_no_hazard got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        in_valid = 1'b1; out_ready = 1'b1;
        instr = mk(6'h00, 5'd4, 5'd25, 16'h0010); in_pc = 32'h400;
        tick();
        out_ready = 1'b0; instr = mk(6'h00, 5'd25, 5'd4, 16'h0020); in_pc = 32'h404;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %b want 0", i, in_ready); end
            n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h400 || out_opA !== 32'd69 || out_opB !== 32'd7 || out_imm !== 32'h10)
                begin n_fail++; $display("FAIL stall_hold[%0d] got %b/%h/%0d/%0d/%h want 1/400/69/7/10", i, out_valid, out_pc, out_opA, out_opB, out_imm); end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_pc !== 32'h404 || out_opA !== 32'd7 || out_opB !== 32'd69) begin n_fail++; $display("FAIL stall_release_capture got %h/%0d/%0d want 404/7/69", out_pc, out_opA, out_opB); end
        tick();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; out_ready = 1'b1;
        instr = mk(6'h00, 5'd1, 5'd2, 16'h0); in_pc = 32'h500;
        tick();
        out_ready = 1'b0; flush = 1'b1; instr = mk(6'h00, 5'd3, 5'd4, 16'h0); in_pc = 32'h504;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept got %b want 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clears got %b want 0", out_valid); end
        n_checks++; if (out_pc === 32'h504) begin n_fail++; $display("FAIL flush_accepted got pc %h want not 504", out_pc); end
        tick();
        out_ready = 1'b1;
    endtask

    task automatic test_reset_stall();
        in_valid = 1'b1; out_ready = 1'b1;
        instr = mk(6'h00, 5'd4, 5'd4, 16'h0); in_pc = 32'h600;
        tick();
        out_ready = 1'b0; instr = mk(6'h00, 5'd25, 5'd25, 16'h0); in_pc = 32'h604;
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_stall_ready got %b want 0", in_ready); end
        tick();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_opA !== 32'h0 || out_opB !== 32'h0 || out_opcode !== 6'h0)
            begin n_fail++; $display("FAIL reset_stall_clear got %b/%h/%h/%h/%h want 0/0/0/0/0", out_valid, out_pc, out_opA, out_opB, out_opcode); end
        reset = 1'b0; out_ready = 1'b1; instr = mk(6'h00, 5'd4, 5'd0, 16'hFFFE); in_pc = 32'h700;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL restart_imm got %b/%h want 1/fffffffe", out_valid, out_imm); end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000 + i;
        regs[0] = 32'd55;
        regs[4] = 32'd69;
        regs[25] = 32'd7;
        test_reset();
        test_basic();
        test_bypass();
        test_load_use();
        test_stall();
        test_flush();
        test_reset_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DATA_W, default 32, datapath and instruction width.
REQ-002 Parameter REG_AW, default 5, register-file address width.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  upstream instruction present.
REQ-006 Port in_ready  output  1  stage accepts instruction this cycle.
REQ-007 Port instr  input  DATA_W  instruction word (rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], opcode=[31:26]).
REQ-008 Port in_pc  input  DATA_W  PC of instr.
REQ-009 Port Aa  output  REG_AW  register-file read address A; combinational, equals instr[25:21].
REQ-010 Port Ab  output  REG_AW  register-file read address B; combinational, equals instr[20:16].
REQ-011 Port Da  input  DATA_W  register-file read data A (asynchronous read).
REQ-012 Port Db  input  DATA_W  register-file read data B (asynchronous read).
REQ-013 Port wb_en  input  1  writeback stage writes register file this cycle.
REQ-014 Port wb_addr  input  REG_AW  writeback destination.
REQ-015 Port wb_data  input  DATA_W  writeback value.
REQ-016 Port flush  input  1  discard held instruction.
REQ-017 Port out_valid  output  1  registered operand bundle valid.
REQ-018 Port out_ready  input  1  downstream accepts bundle.
REQ-019 Ports out_opA, out_opB  output  DATA_W each  registered operands.
REQ-020 Ports out_rs, out_rt, out_rd  output  REG_AW each  registered register numbers.
REQ-021 Port out_imm  output  DATA_W  registered sign-extended imm.
REQ-022 Ports out_pc  output  DATA_W; out_opcode  output  6  registered PC and opcode.

Function
REQ-023 advance SHALL equal (!out_valid || out_ready).
REQ-024 hazard SHALL equal in_valid && out_valid && out_opcode==6'b100011 && out_rt!=0 && (out_rt==instr[25:21] || out_rt==instr[20:16]).
REQ-025 in_ready SHALL equal advance && !hazard && !flush, combinationally.
REQ-026 Accept (in_valid && in_ready) SHALL capture all out_* fields and set out_valid=1 on the next edge; latency 1 cycle.
REQ-027 advance && hazard SHALL load a bubble: out_valid=0, data fields don't-care, instruction held upstream (in_ready=0).
REQ-028 advance && !in_valid SHALL set out_valid=0.
REQ-029 !advance SHALL hold every out_* output bit-stable.
REQ-030 Captured opA SHALL be 0 if rs==0; else wb_data if wb_en && wb_addr==rs; else Da. opB identical using rt, Db.
REQ-031 Writes to register 0 via bypass SHALL be ignored (operand stays 0).
REQ-032 out_imm SHALL be {{16{instr[15]}}, instr[15:0]}.
REQ-033 flush SHALL clear out_valid on the next edge regardless of out_ready, and no instruction is accepted that cycle.
REQ-034 Priority SHALL be reset > flush > hazard > accept.
REQ-035 Stage holds at most one instruction; no instruction duplicated or dropped except by flush.

Reset
REQ-036 reset high at an edge SHALL set out_valid=0 and all out_* data fields to 0.
REQ-037 in_ready SHALL be 0 while reset is high; reset mid-stall SHALL discard held bundle and hazard state.
REQ-038 After reset deasserts, first accept SHALL be possible on the first edge.

Verification
REQ-039 Reg file r4=69; instr rs=4, rt=4, out_ready=1 -> next cycle out_valid=1, out_opA=out_opB=69.
REQ-040 Instr rs=25 with wb_en=1, wb_addr=25, wb_data=420, Da=7 -> out_opA=420; same with wb_addr=0 and rs=0 -> out_opA=0.
REQ-041 Held lw rt=8, next instr rs=8 -> one bubble cycle (in_ready=0, then out_valid=0), instr accepted following cycle.
REQ-042 out_ready=0 for 3 cycles with valid bundle -> outputs unchanged, in_ready=0; out_ready=1 -> new instr captured next edge.
REQ-043 flush with out_valid=1, out_ready=0 -> out_valid=0 next edge, no accept that cycle.
REQ-044 reset asserted during stall -> out_valid=0, all out_* =0 next edge; imm 16'hFFFE -> out_imm=32'hFFFFFFFE after restart.
